// File: rtl/phs_trig_pkg.sv
// Shared encodings and helpers for the PHOS SRU test-trigger sequencer.
package phs_trig_pkg;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'b00,
    MODE_SINGLE   = 2'b01,
    MODE_PERIODIC = 2'b10,
    MODE_EXT      = 2'b11
  } trig_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_L1 = 2'd1,
    ST_WAIT_L2 = 2'd2
  } trig_state_e;

  // Increment that sticks at all-ones for a counter of the given width (<= 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (val == max_val) ? val : val + 64'd1;
  endfunction

endpackage

// File: rtl/phs_trig_tmr.sv
// Loadable down-counter that parks at zero; zero flag is combinational.
module phs_trig_tmr #(
  parameter int CNT_W = 16
) (
  input  logic             ttc_clk40,
  input  logic             brd_reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge ttc_clk40) begin
    if (!brd_reset_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (en && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/phs_test_trig_gen.sv
// L0 -> L1 -> L2a test-trigger sequencer with single, periodic-burst and external modes,
// gated by the unmasked per-DTC busy vector.
module phs_test_trig_gen
  import phs_trig_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 12,
  parameter int NUM_CH  = 40,
  parameter int EVCNT_W = 32
) (
  input  logic               ttc_clk40,
  input  logic               brd_reset_n,
  input  logic               cfg_en,
  input  logic [1:0]         cfg_mode,
  input  logic               cfg_start,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [CNT_W-1:0]   cfg_l1_lat,
  input  logic [CNT_W-1:0]   cfg_l2_lat,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               htrig,
  input  logic [NUM_CH-1:0]  busy_in,
  input  logic [NUM_CH-1:0]  busy_mask,
  output logic               trig_l0,
  output logic               trig_l1,
  output logic               trig_l2a,
  output logic               seq_busy,
  output logic               burst_done,
  output logic [EVCNT_W-1:0] trig_cnt,
  output logic [EVCNT_W-1:0] drop_cnt
);

  // A programmed cycle count N becomes a timer load of N-1 (0 behaves as 1).
  function automatic logic [CNT_W-1:0] lat_m1(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  trig_state_e        state_reg, state_next;
  trig_mode_e         mode_cur, mode_reg;
  logic               htrig_d_reg;
  logic               l0_reg, l0_next, l1_reg, l1_next, l2a_reg, l2a_next;
  logic [CNT_W-1:0]   l2_lat_reg, l2_lat_next;
  logic               run_reg, run_next;
  logic               burst_done_reg, burst_done_next;
  logic [BURST_W-1:0] burst_cnt_reg, burst_cnt_next;
  logic [EVCNT_W-1:0] trig_cnt_reg, trig_cnt_next, drop_cnt_reg, drop_cnt_next;
  logic               lat_load, lat_zero, per_load, per_zero;
  logic [CNT_W-1:0]   lat_load_val, per_load_val;
  logic [NUM_CH-1:0]  busy_eff;
  logic               any_busy, abort, per_expire, request, accept;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_busy
    assign busy_eff[gi] = busy_in[gi] & ~busy_mask[gi];
  end

  assign any_busy   = |busy_eff;
  assign mode_cur   = trig_mode_e'(cfg_mode);
  assign abort      = !cfg_en || (mode_cur != mode_reg);
  assign per_expire = run_reg && per_zero;

  always_comb begin
    request = 1'b0;
    if (!abort) begin
      case (mode_cur)
        MODE_SINGLE:   request = cfg_start;
        MODE_PERIODIC: request = per_expire;
        MODE_EXT:      request = htrig && !htrig_d_reg;
        default:       request = 1'b0;
      endcase
    end
  end

  assign accept = request && (state_reg == ST_IDLE) && !any_busy;

  phs_trig_tmr #(.CNT_W(CNT_W)) u_lat_tmr (
    .ttc_clk40   (ttc_clk40),
    .brd_reset_n (brd_reset_n),
    .load        (lat_load),
    .load_val    (lat_load_val),
    .en          (state_reg != ST_IDLE),
    .zero        (lat_zero)
  );

  phs_trig_tmr #(.CNT_W(CNT_W)) u_per_tmr (
    .ttc_clk40   (ttc_clk40),
    .brd_reset_n (brd_reset_n),
    .load        (per_load),
    .load_val    (per_load_val),
    .en          (run_reg),
    .zero        (per_zero)
  );

  always_ff @(posedge ttc_clk40) begin
    if (!brd_reset_n) begin
      state_reg      <= ST_IDLE;
      mode_reg       <= MODE_OFF;
      htrig_d_reg    <= 1'b0;
      l0_reg         <= 1'b0;
      l1_reg         <= 1'b0;
      l2a_reg        <= 1'b0;
      l2_lat_reg     <= '0;
      run_reg        <= 1'b0;
      burst_done_reg <= 1'b0;
      burst_cnt_reg  <= '0;
      trig_cnt_reg   <= '0;
      drop_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      mode_reg       <= mode_cur;
      htrig_d_reg    <= htrig;
      l0_reg         <= l0_next;
      l1_reg         <= l1_next;
      l2a_reg        <= l2a_next;
      l2_lat_reg     <= l2_lat_next;
      run_reg        <= run_next;
      burst_done_reg <= burst_done_next;
      burst_cnt_reg  <= burst_cnt_next;
      trig_cnt_reg   <= trig_cnt_next;
      drop_cnt_reg   <= drop_cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:    if (accept)   state_next = ST_WAIT_L1;
        ST_WAIT_L1: if (lat_zero) state_next = ST_WAIT_L2;
        ST_WAIT_L2: if (lat_zero) state_next = ST_IDLE;
        default:                  state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    l0_next         = 1'b0;
    l1_next         = 1'b0;
    l2a_next        = 1'b0;
    lat_load        = 1'b0;
    lat_load_val    = '0;
    l2_lat_next     = l2_lat_reg;
    run_next        = run_reg;
    per_load        = 1'b0;
    per_load_val    = '0;
    burst_cnt_next  = burst_cnt_reg;
    burst_done_next = burst_done_reg;

    if (abort) begin
      // Clearing both timers guarantees no stale L1/L2a or expiry after an abort.
      lat_load = 1'b1;
      run_next = 1'b0;
      per_load = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: if (accept) begin
          l0_next      = 1'b1;
          lat_load     = 1'b1;
          lat_load_val = lat_m1(cfg_l1_lat);
          l2_lat_next  = cfg_l2_lat;
        end
        ST_WAIT_L1: if (lat_zero) begin
          l1_next      = 1'b1;
          lat_load     = 1'b1;
          lat_load_val = lat_m1(l2_lat_reg);
        end
        ST_WAIT_L2: if (lat_zero) l2a_next = 1'b1;
        default: ;
      endcase

      if ((mode_cur == MODE_PERIODIC) && cfg_start) begin
        run_next        = 1'b1;
        per_load        = 1'b1;
        per_load_val    = lat_m1(cfg_period);
        burst_cnt_next  = '0;
        burst_done_next = 1'b0;
      end else if (per_expire) begin
        per_load     = 1'b1;
        per_load_val = lat_m1(cfg_period);
        if (accept) begin
          burst_cnt_next = burst_cnt_reg + BURST_W'(1);
          if ((cfg_burst != '0) && (burst_cnt_next >= cfg_burst)) begin
            run_next        = 1'b0;
            burst_done_next = 1'b1;
          end
        end
      end
    end

    trig_cnt_next = l0_next ? EVCNT_W'(sat_inc(64'(trig_cnt_reg), EVCNT_W)) : trig_cnt_reg;
    drop_cnt_next = (request && !accept) ? EVCNT_W'(sat_inc(64'(drop_cnt_reg), EVCNT_W))
                                         : drop_cnt_reg;
  end

  assign trig_l0    = l0_reg;
  assign trig_l1    = l1_reg;
  assign trig_l2a   = l2a_reg;
  assign seq_busy   = (state_reg != ST_IDLE) || l2a_reg;
  assign burst_done = burst_done_reg;
  assign trig_cnt   = trig_cnt_reg;
  assign drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_phs_test_trig_gen.sv
// Scoreboard bench: expected pulses are queued with their cycle when stimulus is driven.
`timescale 1ns/1ps
module tb_phs_test_trig_gen;

  localparam int CNT_W = 16, BURST_W = 12, NUM_CH = 40, EVCNT_W = 32;
  localparam logic [2:0] K_L0 = 3'b001, K_L1 = 3'b010, K_L2A = 3'b100;

  logic               ttc_clk40 = 1'b0;
  logic               brd_reset_n, cfg_en, cfg_start, htrig;
  logic [1:0]         cfg_mode;
  logic [CNT_W-1:0]   cfg_period, cfg_l1_lat, cfg_l2_lat;
  logic [BURST_W-1:0] cfg_burst;
  logic [NUM_CH-1:0]  busy_in, busy_mask;
  logic               trig_l0, trig_l1, trig_l2a, seq_busy, burst_done;
  logic [EVCNT_W-1:0] trig_cnt, drop_cnt;

  typedef struct {
    int         cyc;
    logic [2:0] kind;
  } ev_t;

  ev_t sb_q[$];
  int  cyc = 0;
  int  n_checks = 0, n_fail = 0;
  int  exp_trig = 0, exp_drop = 0;
  logic prev_l2a = 1'b0;

  phs_test_trig_gen #(
    .CNT_W(CNT_W), .BURST_W(BURST_W), .NUM_CH(NUM_CH), .EVCNT_W(EVCNT_W)
  ) dut (
    .ttc_clk40   (ttc_clk40),
    .brd_reset_n (brd_reset_n),
    .cfg_en      (cfg_en),
    .cfg_mode    (cfg_mode),
    .cfg_start   (cfg_start),
    .cfg_period  (cfg_period),
    .cfg_l1_lat  (cfg_l1_lat),
    .cfg_l2_lat  (cfg_l2_lat),
    .cfg_burst   (cfg_burst),
    .htrig       (htrig),
    .busy_in     (busy_in),
    .busy_mask   (busy_mask),
    .trig_l0     (trig_l0),
    .trig_l1     (trig_l1),
    .trig_l2a    (trig_l2a),
    .seq_busy    (seq_busy),
    .burst_done  (burst_done),
    .trig_cnt    (trig_cnt),
    .drop_cnt    (drop_cnt)
  );

  always #12 ttc_clk40 = ~ttc_clk40;
  always @(posedge ttc_clk40) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge ttc_clk40);
      #1;
    end
  endtask

  // Queue one full L0/L1/L2a sequence whose L0 is expected in cycle c0.
  task automatic exp_seq(input int c0, input int l1, input int l2, input bit full = 1'b1);
    int a, b;
    ev_t e;
    a = (l1 == 0) ? 1 : l1;
    b = (l2 == 0) ? 1 : l2;
    e.cyc = c0;         e.kind = K_L0;  sb_q.push_back(e);
    e.cyc = c0 + a;     e.kind = K_L1;  sb_q.push_back(e);
    if (full) begin
      e.cyc = c0 + a + b; e.kind = K_L2A; sb_q.push_back(e);
    end
    exp_trig++;
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic set_mode(input logic [1:0] m);
    cfg_mode = m;
    tick(2);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_trig_cnt"}, trig_cnt, exp_trig);
    chk({tag, "_drop_cnt"}, drop_cnt, exp_drop);
    chk({tag, "_sb_empty"}, sb_q.size(), 0);
  endtask

  always @(negedge ttc_clk40) begin : monitor
    logic [2:0] obs;
    ev_t ev;
    obs = {trig_l2a, trig_l1, trig_l0};
    if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      chk("missed_pulse_cycle", cyc, sb_q[0].cyc);
      void'(sb_q.pop_front());
    end
    if (obs != 3'b000) begin
      if (sb_q.size() == 0) begin
        chk("spurious_pulse", obs, 0);
      end else begin
        ev = sb_q.pop_front();
        chk("pulse_kind", obs, ev.kind);
        chk("pulse_cycle", cyc, ev.cyc);
      end
      chk("seq_busy_during_pulse", seq_busy, 1);
    end
    if (prev_l2a) chk("seq_busy_after_l2a", seq_busy, 0);
    prev_l2a = trig_l2a;
  end

  initial begin
    int s;
    brd_reset_n = 1'b0;
    cfg_en      = 1'b0;
    cfg_mode    = 2'b00;
    cfg_start   = 1'b0;
    cfg_period  = '0;
    cfg_l1_lat  = 16'd100;
    cfg_l2_lat  = 16'd212;
    cfg_burst   = '0;
    htrig       = 1'b0;
    busy_in     = '0;
    busy_mask   = '1;
    tick(3);
    chk("rst_pulses", {trig_l0, trig_l1, trig_l2a}, 0);
    chk("rst_seq_busy", seq_busy, 0);
    chk("rst_burst_done", burst_done, 0);
    chk("rst_trig_cnt", trig_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    brd_reset_n = 1'b1;
    cfg_en      = 1'b1;

    // Single shot, L1=100 L2=212
    set_mode(2'b01);
    exp_seq(cyc + 1, 100, 212);
    pulse_start();
    tick(50);
    chk("single_seq_busy_mid", seq_busy, 1);
    tick(350);
    chk_counts("single");

    // Zero latencies give three consecutive pulses
    cfg_l1_lat = '0;
    cfg_l2_lat = '0;
    exp_seq(cyc + 1, 0, 0);
    pulse_start();
    tick(10);
    chk_counts("zero_lat");

    // Periodic burst of 3, period 5000, then re-arm
    cfg_l1_lat = 16'd100;
    cfg_l2_lat = 16'd212;
    cfg_period = 16'd5000;
    cfg_burst  = 12'd3;
    set_mode(2'b10);
    for (int r = 0; r < 2; r++) begin
      s = cyc;
      for (int k = 1; k <= 3; k++) exp_seq(s + 1 + 5000 * k, 100, 212);
      pulse_start();
      chk("burst_done_cleared", burst_done, 0);
      tick(3 * 5000 + 400);
      chk("burst_done_set", burst_done, 1);
      tick(5000);
      chk_counts("periodic_burst");
    end

    // External mode with an unmasked busy link: every edge is dropped
    cfg_l1_lat   = 16'd3;
    cfg_l2_lat   = 16'd4;
    busy_in[7]   = 1'b1;
    busy_mask[7] = 1'b0;
    set_mode(2'b11);
    for (int k = 0; k < 4; k++) begin
      htrig = 1'b1;
      tick(2);
      htrig = 1'b0;
      tick(2);
      exp_drop++;
    end
    chk_counts("ext_busy");
    busy_mask[7] = 1'b1;
    tick();
    exp_seq(cyc + 1, 3, 4);
    htrig = 1'b1;
    tick(3);
    htrig = 1'b0;
    tick(20);
    chk_counts("ext_masked");
    busy_in[7] = 1'b0;

    // Period shorter than a sequence: expiries alternate accept/drop
    cfg_l1_lat = 16'd100;
    cfg_l2_lat = 16'd212;
    cfg_period = 16'd200;
    cfg_burst  = '0;
    set_mode(2'b10);
    s = cyc;
    for (int k = 1; k <= 5; k += 2) exp_seq(s + 1 + 200 * k, 100, 212);
    exp_drop += 3;
    pulse_start();
    tick(s + 1350 - cyc);
    set_mode(2'b00);
    tick(300);
    chk_counts("alt_drop");

    // cfg_en removed in cycle 50 of WAIT_L1
    set_mode(2'b01);
    exp_seq(cyc + 1, 100, 212, 1'b0);
    void'(sb_q.pop_back());
    pulse_start();
    tick(49);
    cfg_en = 1'b0;
    tick();
    chk("en_abort_seq_busy", seq_busy, 0);
    tick(400);
    chk_counts("en_abort");
    cfg_en = 1'b1;
    tick(2);

    // Reset in the middle of WAIT_L2
    cfg_l1_lat = 16'd10;
    exp_seq(cyc + 1, 10, 212, 1'b0);
    pulse_start();
    tick(60);
    chk("pre_rst_seq_busy", seq_busy, 1);
    brd_reset_n = 1'b0;
    tick();
    exp_trig = 0;
    exp_drop = 0;
    chk("midrst_seq_busy", seq_busy, 0);
    chk("midrst_burst_done", burst_done, 0);
    brd_reset_n = 1'b1;
    tick(300);
    chk_counts("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
